speed_governor: RTL and testbench

Throttle regulation stage downstream of the two-cycle overspeed detector. Consumes the detector's sustained-overspeed flag together with driver accelerate/brake requests, and maintains a saturating throttle duty setpoint. Ramps the setpoint up on request, steps it down while overspeed persists, and holds it for a settle window afterwards. Drives the throttle actuator through an internal PWM generator.

---
 rtl/speed_governor.sv | 196 +++++++++++++++++++
 tb/tb_speed_governor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/speed_governor.sv
// -----------------------------------------------------------------------------
// speed_governor
//
// Throttle regulation stage that sits after the overspeed detector. It keeps a
// saturating throttle duty setpoint, ramps it up while the driver asks for
// acceleration, steps it down while sustained overspeed persists, and then
// holds it for a settle window. The setpoint drives an internal PWM generator.
//
// Ports:
//   clk        system clock, rising edge
//   clr_bar    synchronous active-low reset
//   overspeed  sustained-overspeed flag from the detector stage
//   accel_req  driver accelerate request (level)
//   brake      driver brake (level), highest priority
//   duty       current throttle setpoint, registered
//   pwm_out    throttle PWM, registered, one cycle behind duty
//   limiting   high while in DECEL or HOLD
//   state      IDLE=00, ACCEL=01, DECEL=10, HOLD=11
//
// Build option:
//   SPEED_GOV_SOFT_BRAKE_EN  when defined, brake ramps duty down by DEC_STEP
//                            per step tick instead of zeroing it at once.
// -----------------------------------------------------------------------------
module speed_governor #(
    parameter int DUTY_W   = 8,
    parameter int MAX_DUTY = 200,
    parameter int STEP_DIV = 16,
    parameter int INC_STEP = 1,
    parameter int DEC_STEP = 8,
    parameter int HOLD_CYC = 32
) (
    input  logic              clk,
    input  logic              clr_bar,
    input  logic              overspeed,
    input  logic              accel_req,
    input  logic              brake,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              limiting,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCEL = 2'b01,
        DECEL = 2'b10,
        HOLD  = 2'b11
    } state_t;

    localparam int GW     = DUTY_W + 1;  // duty width plus one guard bit
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              limiting_q;
    logic [STEP_W-1:0] step_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              step_tick;

    // -------------------------------------------------------------------------
    // Step-tick divider: free-running, deliberately not tied to FSM state so
    // the step cadence is the same no matter when a state was entered.
    // -------------------------------------------------------------------------
    assign step_tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values; blocking here would create
        // order-dependent races between always_ff blocks.
        if (!clr_bar) begin
            step_cnt <= '0;
        end else if (step_tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + STEP_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Saturating duty arithmetic. The guard bit catches both overflow past
    // MAX_DUTY and borrow below zero.
    // -------------------------------------------------------------------------
    logic [GW-1:0]     duty_inc, duty_dec;
    logic [DUTY_W-1:0] duty_up, duty_down;

    assign duty_inc  = {1'b0, duty_q} + GW'(INC_STEP);
    assign duty_dec  = {1'b0, duty_q} - GW'(DEC_STEP);
    assign duty_up   = (duty_inc > {1'b0, MAX_D}) ? MAX_D : duty_inc[DUTY_W-1:0];
    assign duty_down = duty_dec[DUTY_W] ? '0 : duty_dec[DUTY_W-1:0];

    // -------------------------------------------------------------------------
    // Next-state / next-duty logic. Duty updates follow the current state, so
    // a step tick on the edge that leaves ACCEL or DECEL still takes effect.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;

        if (brake) begin
            state_d = IDLE;
            hold_d  = '0;
`ifdef SPEED_GOV_SOFT_BRAKE_EN
            if (step_tick) begin
                duty_d = duty_down;
            end
`else
            duty_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (overspeed) begin
                        state_d = DECEL;
                    end else if (accel_req) begin
                        state_d = ACCEL;
                    end
                end
                ACCEL: begin
                    if (step_tick) begin
                        duty_d = duty_up;
                    end
                    if (overspeed) begin
                        state_d = DECEL;
                    end else if (!accel_req) begin
                        state_d = IDLE;
                    end
                end
                DECEL: begin
                    if (step_tick) begin
                        duty_d = duty_down;
                    end
                    if (!overspeed) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    // Overspeed wins over expiry, so re-assertion on the
                    // final hold cycle goes back to DECEL.
                    if (overspeed) begin
                        state_d = DECEL;
                    end else if (hold_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            hold_q     <= '0;
            limiting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            hold_q     <= hold_d;
            limiting_q <= (state_d == DECEL) || (state_d == HOLD);
        end
    end

    // -------------------------------------------------------------------------
    // PWM generator. Compares against the registered duty, which gives the
    // one-cycle lag from duty to pwm_out.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            pwm_out <= (pwm_cnt < duty_q);
        end
    end

    assign duty     = duty_q;
    assign state    = state_q;
    assign limiting = limiting_q;

endmodule

// File: tb/tb_speed_governor.sv
// -----------------------------------------------------------------------------
// tb_speed_governor
//
// Self-checking bench for speed_governor with default parameters. A table of
// {inputs held for N edges, expected state/duty/limiting} records walks one
// long scenario; hand-written sequences cover PWM duty, reset mid-ramp and
// overspeed re-assertion at the end of HOLD.
// -----------------------------------------------------------------------------
module tb_speed_governor;

    logic       clk;
    logic       clr_bar;
    logic       overspeed;
    logic       accel_req;
    logic       brake;
    logic [7:0] duty;
    logic       pwm_out;
    logic       limiting;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ACCEL = 2'b01;
    localparam logic [1:0] S_DECEL = 2'b10;
    localparam logic [1:0] S_HOLD  = 2'b11;

    speed_governor dut (
        .clk       (clk),
        .clr_bar   (clr_bar),
        .overspeed (overspeed),
        .accel_req (accel_req),
        .brake     (brake),
        .duty      (duty),
        .pwm_out   (pwm_out),
        .limiting  (limiting),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         n;
        logic       clr_bar;
        logic       overspeed;
        logic       accel_req;
        logic       brake;
        logic [1:0] exp_state;
        logic [7:0] exp_duty;
        logic       exp_lim;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input int n, input logic c,
                           input logic o, input logic a, input logic b,
                           input logic [1:0] es, input logic [7:0] ed,
                           input logic el);
        vec_t v;
        v.name = name; v.n = n; v.clr_bar = c; v.overspeed = o;
        v.accel_req = a; v.brake = b; v.exp_state = es; v.exp_duty = ed;
        v.exp_lim = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clr_bar = 1'b0; overspeed = 1'b0; accel_req = 1'b0; brake = 1'b0;
        run(1);
        clr_bar = 1'b1;
    endtask

    int pwm_high;

    initial begin
        clr_bar = 1'b0; overspeed = 1'b0; accel_req = 1'b0; brake = 1'b0;

        // Edge numbers in comments count from the last reset edge (E0).
        // Step ticks land on edges that are multiples of 16.
        //       name          n     clr os acc brk state    duty lim
        add_vec("reset",         2,   0,  0, 0,  0, S_IDLE,    0, 0);
        add_vec("ramp10",      160,   1,  0, 1,  0, S_ACCEL,  10, 0); // E160
        add_vec("idle_frz",      5,   1,  0, 0,  0, S_IDLE,   10, 0); // E165
        add_vec("ramp16",      100,   1,  0, 1,  0, S_ACCEL,  16, 0); // E265
        add_vec("ramp20",       64,   1,  0, 1,  0, S_ACCEL,  20, 0); // E329
        add_vec("os_accel",      1,   1,  1, 1,  0, S_DECEL,  20, 1); // E330
        add_vec("dec12",         6,   1,  1, 0,  0, S_DECEL,  12, 1); // E336
        add_vec("dec4",         16,   1,  1, 0,  0, S_DECEL,   4, 1); // E352
        add_vec("dec0",         16,   1,  1, 0,  0, S_DECEL,   0, 1); // E368
        add_vec("dec_floor",    16,   1,  1, 0,  0, S_DECEL,   0, 1); // E384
        add_vec("hold_enter",    1,   1,  0, 0,  0, S_HOLD,    0, 1); // E385
        add_vec("hold_last",    31,   1,  0, 0,  0, S_HOLD,    0, 1); // E416
        add_vec("hold_exit",     1,   1,  0, 0,  0, S_IDLE,    0, 0); // E417
        add_vec("sat200",     4000,   1,  0, 1,  0, S_ACCEL, 200, 0); // E4417
        add_vec("sat_stay",     32,   1,  0, 1,  0, S_ACCEL, 200, 0); // E4449
`ifdef SPEED_GOV_SOFT_BRAKE_EN
        add_vec("brake_os",      1,   1,  1, 1,  1, S_IDLE,  200, 0); // E4450
        add_vec("brake_held",   20,   1,  1, 1,  1, S_IDLE,  192, 0); // E4470
        add_vec("brake_rel",     2,   1,  0, 0,  0, S_IDLE,  192, 0); // E4472
`else
        add_vec("brake_os",      1,   1,  1, 1,  1, S_IDLE,    0, 0); // E4450
        add_vec("brake_held",   20,   1,  1, 1,  1, S_IDLE,    0, 0); // E4470
        add_vec("brake_rel",     2,   1,  0, 0,  0, S_IDLE,    0, 0); // E4472
`endif

        foreach (vecs[i]) begin
            clr_bar   = vecs[i].clr_bar;
            overspeed = vecs[i].overspeed;
            accel_req = vecs[i].accel_req;
            brake     = vecs[i].brake;
            run(vecs[i].n);
            check($sformatf("%s_state", vecs[i].name), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("%s_duty", vecs[i].name), 32'(duty), 32'(vecs[i].exp_duty));
            check($sformatf("%s_lim", vecs[i].name), 32'(limiting), 32'(vecs[i].exp_lim));
        end

        // PWM: duty frozen at 10 gives exactly 10 high cycles per 256.
        do_reset();
        check("pwm_after_reset", 32'(pwm_out), 32'd0);
        accel_req = 1'b1;
        run(160);
        check("pwm_duty10", 32'(duty), 32'd10);
        accel_req = 1'b0;
        run(10);
        pwm_high = 0;
        repeat (256) begin
            if (pwm_out) pwm_high++;
            run(1);
        end
        check("pwm_high_count", 32'(pwm_high), 32'd10);

        // Reset mid-ramp at duty 57 clears everything on one edge.
        do_reset();
        accel_req = 1'b1;
        run(912);
        check("ramp57_duty", 32'(duty), 32'd57);
        check("ramp57_state", 32'(state), 32'(S_ACCEL));
        clr_bar = 1'b0;
        run(1);
        check("rst57_duty", 32'(duty), 32'd0);
        check("rst57_state", 32'(state), 32'(S_IDLE));
        check("rst57_pwm", 32'(pwm_out), 32'd0);
        check("rst57_lim", 32'(limiting), 32'd0);
        clr_bar   = 1'b1;
        accel_req = 1'b0;

        // Overspeed back on the 31st of 32 HOLD cycles returns to DECEL,
        // and the next HOLD runs a fresh full window.
        do_reset();
        overspeed = 1'b1;
        run(1);
        check("hr_decel", 32'(state), 32'(S_DECEL));
        overspeed = 1'b0;
        run(1);
        check("hr_hold1", 32'(state), 32'(S_HOLD));
        run(30);
        check("hr_hold31", 32'(state), 32'(S_HOLD));
        overspeed = 1'b1;
        run(1);
        check("hr_redecel", 32'(state), 32'(S_DECEL));
        check("hr_redecel_lim", 32'(limiting), 32'd1);
        overspeed = 1'b0;
        run(1);
        check("hr_hold_again", 32'(state), 32'(S_HOLD));
        run(31);
        check("hr_hold_full", 32'(state), 32'(S_HOLD));
        run(1);
        check("hr_idle", 32'(state), 32'(S_IDLE));
        check("hr_idle_lim", 32'(limiting), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
